// File: rtl/pixel_if_pkg.sv
// Shared pixel-interface constants and the write-scheduler FSM encoding.
// The column mux imports the same package, so the pixel geometry stays in one place.
package pixel_if_pkg;

  localparam int BITS_PER_PIXEL = 24;
  localparam int ADDR_W         = 6;
  localparam int PIXELS_PER_COL = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_GUARD     = 3'd4;

endpackage

// File: rtl/pixel_write_scheduler_rr_arbiter.sv
// Round-robin pick: first valid requester at or after the pointer, wrapping.
// Produces both the one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [1:0]      idx_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && valid_i[k] && (k == (int'(ptr_i) + i) % NREQ)) begin
          onehot_o[k] = 1'b1;
          idx_o       = 2'(k);
          found       = 1'b1;
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Frame-granular owner of the column mux pixel write port, with send/guard sequencing.
// Optional stall abort is compiled in with PWS_TIMEOUT_EN.
module pixel_write_scheduler #(
  parameter int NREQ           = 2,
  parameter int BITS_PER_PIXEL = pixel_if_pkg::BITS_PER_PIXEL,
  parameter int ADDR_W         = pixel_if_pkg::ADDR_W,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT        = 4095
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_last,
  input  logic [NREQ*ADDR_W-1:0]        req_addr,
  input  logic [NREQ*BITS_PER_PIXEL-1:0] req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          write_en,
  output logic [ADDR_W-1:0]             pixel_addr,
  output logic [BITS_PER_PIXEL-1:0]     pixel_value,
  output logic                          send_frame,
  input  logic                          frame_done,
  output logic [1:0]                    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);
  import pixel_if_pkg::*;

  localparam int GW = $clog2(GUARD_CYCLES);

  logic [2:0]                state_q, state_d;
  logic [1:0]                grant_q, grant_d, rr_ptr_q, rr_ptr_d, next_ptr;
  logic [NREQ-1:0]           gnt_oh_q, gnt_oh_d, arb_oh;
  logic [1:0]                arb_idx;
  logic                      arb_any;
  logic [GW-1:0]             guard_q, guard_d;
  logic                      write_en_q, send_frame_q, send_d;
  logic [ADDR_W-1:0]         pixel_addr_q, sel_addr;
  logic [BITS_PER_PIXEL-1:0] pixel_value_q, sel_data;
  logic                      in_write, accept, own_last, stall_expired;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (arb_oh),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  assign in_write = (state_q == S_WRITE);
  assign accept   = in_write && |(req_valid & gnt_oh_q);
  assign own_last = |(req_last & gnt_oh_q);
  assign next_ptr = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh_q[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*BITS_PER_PIXEL +: BITS_PER_PIXEL];
      end
    end
  end

`ifdef PWS_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;
  logic          timeout_err_q;

  // The stall count only runs while the owner holds the port without delivering beats
  assign stall_expired = in_write && !accept && (stall_q == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= (!in_write || accept) ? '0 : stall_q + 1'b1;
      timeout_err_q <= stall_expired;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign stall_expired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    rr_ptr_d = rr_ptr_q;
    guard_d  = guard_q;
    send_d   = 1'b0;
    case (state_q)
      S_IDLE: if (arb_any) begin
        grant_d  = arb_idx;
        gnt_oh_d = arb_oh;
        state_d  = S_WRITE;
      end
      S_WRITE: if (accept && own_last) begin
        state_d  = S_WAIT_DONE;
        rr_ptr_d = next_ptr;
      end else if (stall_expired) begin
        state_d  = S_IDLE;
        rr_ptr_d = next_ptr;
      end
      // The last beat is already on the mux, so a frame_done on the entry cycle is valid
      S_WAIT_DONE: if (frame_done) begin
        state_d = S_SEND;
        send_d  = 1'b1;
      end
      S_SEND: begin
        state_d = S_GUARD;
        guard_d = '0;
      end
      // The mux swaps buffers a cycle after send_frame; keep writes off until that settles
      S_GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = S_IDLE;
        else                                   guard_d = guard_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      gnt_oh_q      <= '0;
      rr_ptr_q      <= '0;
      guard_q       <= '0;
      write_en_q    <= 1'b0;
      pixel_addr_q  <= '0;
      pixel_value_q <= '0;
      send_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gnt_oh_q     <= gnt_oh_d;
      rr_ptr_q     <= rr_ptr_d;
      guard_q      <= guard_d;
      write_en_q   <= accept;
      send_frame_q <= send_d;
      if (accept) begin
        pixel_addr_q  <= sel_addr;
        pixel_value_q <= sel_data;
      end
    end
  end

  assign req_ready   = in_write ? gnt_oh_q : '0;
  assign write_en    = write_en_q;
  assign pixel_addr  = pixel_addr_q;
  assign pixel_value = pixel_value_q;
  assign send_frame  = send_frame_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Directed-plus-random bench for pixel_write_scheduler (two requesters).
// Defining PWS_TIMEOUT_EN also builds the DUT with TIMEOUT=16 and runs the stall-abort step.
module tb_pixel_write_scheduler;

`ifdef PWS_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 4095;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic        write_en, send_frame, frame_done, busy, timeout_err;
  logic [5:0]  pixel_addr;
  logic [23:0] pixel_value;
  logic [1:0]  grant_id;

  int checks = 0, passes = 0, fails = 0;
  int ptr;
  bit exp_pend;
  logic [5:0]  exp_addr;
  logic [23:0] exp_data;
  int tr, tother;

  always #5 clk = ~clk;

  pixel_write_scheduler #(
    .NREQ(2), .BITS_PER_PIXEL(24), .ADDR_W(6), .GUARD_CYCLES(2), .TIMEOUT(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .write_en(write_en), .pixel_addr(pixel_addr), .pixel_value(pixel_value),
    .send_frame(send_frame), .frame_done(frame_done), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_beat(input int r, input logic [5:0] a, input logic [23:0] d, input logic last);
    req_valid[r]            = 1'b1;
    req_last[r]             = last;
    req_addr[r*6 +: 6]      = a;
    req_data[r*24 +: 24]    = d;
  endtask

  // Pixels land on the mux exactly one cycle after their handshake
  task automatic chk_wr();
    chk("write_en", write_en, exp_pend);
    if (exp_pend) begin
      chk("pixel_addr", pixel_addr, exp_addr);
      chk("pixel_value", pixel_value, exp_data);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_write_en", write_en, 0);
    chk("rst_send", send_frame, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_addr", pixel_addr, 0);
    chk("rst_value", pixel_value, 0);
    chk("rst_timeout", timeout_err, 0);
    req_valid = '0; req_last = '0; frame_done = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_pend = 1'b0;
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_send", send_frame, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_write", write_en, 0);
    end
  endtask

  // One complete ownership of the port by requester r; entered and left on an idle negedge
  task automatic frame(input int r, input int n, input bit other, input int stall_at,
                       input int stall_len, input bit rnd_stall, input bit fd_in_write,
                       input int fd_delay, input int rst_after, input bit mul3);
    int o, b, st;
    bit nxt;
    logic [5:0]  a;
    logic [23:0] d;
    o = 1 - r; b = 0; st = 0;
    chk("idle_busy", busy, 0);
    chk("idle_ready", req_ready, 0);
    req_valid[o] = 1'b0;
    if (other) drive_beat(o, 6'($urandom_range(63)), 24'($urandom), 1'b0);
    drive_beat(r, 6'd0, 24'd0, 1'b0);
    step();
    exp_pend = 1'b0;
    while (b < n) begin
      chk("ready_owner", req_ready, 64'(1) << r);
      chk("grant_id", grant_id, r);
      chk("busy_write", busy, 1);
      chk("send_in_write", send_frame, 0);
      chk("timeout_quiet", timeout_err, 0);
      chk_wr();
      if (b == rst_after) begin
        do_reset();
        return;
      end
      if ((b == stall_at && st < stall_len) || (rnd_stall && $urandom_range(3) == 0)) begin
        if (b == stall_at) st++;
        req_valid[r] = 1'b0;
        nxt = 1'b0;
      end else begin
        a = mul3 ? 6'(b) : 6'($urandom_range(63));
        d = mul3 ? 24'(b * 3) : 24'($urandom);
        drive_beat(r, a, d, b == n - 1);
        nxt = 1'b1;
        b++;
      end
      frame_done = fd_in_write ? 1'($urandom_range(1)) : 1'b0;
      step();
      exp_pend = nxt;
      if (nxt) begin exp_addr = a; exp_data = d; end
    end
    frame_done = 1'b0;
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
    chk_wr();
    chk("ready_wait", req_ready, 0);
    chk("busy_wait", busy, 1);
    chk("send_wait", send_frame, 0);
    exp_pend = 1'b0;
    for (int k = 0; k < fd_delay; k++) begin
      step();
      chk("send_early", send_frame, 0);
      chk("write_wait", write_en, 0);
      chk("ready_wait2", req_ready, 0);
    end
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    chk("send_pulse", send_frame, 1);
    chk("write_send", write_en, 0);
    for (int g = 0; g < 2; g++) begin
      step();
      chk("send_single", send_frame, 0);
      chk("guard_busy", busy, 1);
      chk("guard_write", write_en, 0);
      chk("guard_ready", req_ready, 0);
    end
    step();
    chk("back_idle", busy, 0);
    chk("last_owner", grant_id, r);
    ptr = (r + 1) % 2;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_addr = '0; req_data = '0;
    frame_done = 1'b0; ptr = 0; exp_pend = 1'b0; exp_addr = '0; exp_data = '0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_write", write_en, 0);
    chk("reset_send", send_frame, 0);
    chk("reset_grant", grant_id, 0);
    chk("reset_value", pixel_value, 0);
    rst_n = 1'b1;
    step();

    // Both valid after reset: req0 first, req1 right after
    frame(0, 8, 1'b1, -1, 0, 1'b0, 1'b0, 2, -1, 1'b0);
    frame(1, 8, 1'b0, -1, 0, 1'b0, 1'b0, 1, -1, 1'b0);
    // Full 64-pixel frame, data = addr*3
    frame(0, 64, 1'b0, -1, 0, 1'b0, 1'b0, 1, -1, 1'b1);
    // frame_done noise during WRITE, real one on WAIT_DONE entry
    frame(1, 12, 1'b0, -1, 0, 1'b1, 1'b1, 0, -1, 1'b0);
    // Owner pauses 10 cycles while req1 waits
    frame(0, 16, 1'b1, 5, 10, 1'b0, 1'b0, 3, -1, 1'b0);
    for (int i = 0; i < 6; i++)
      frame(ptr, 1 + $urandom_range(20), 1'($urandom_range(1)), -1, 0, 1'b1,
            1'($urandom_range(1)), $urandom_range(3), -1, 1'b0);
    // Reset mid-frame while the pointer favours req1
    if (ptr == 0) frame(0, 4, 1'b0, -1, 0, 1'b0, 1'b0, 0, -1, 1'b0);
    frame(0, 30, 1'b0, -1, 0, 1'b0, 1'b0, 0, 20, 1'b0);
    frame(0, 4, 1'b1, -1, 0, 1'b0, 1'b0, 1, -1, 1'b0);

`ifdef PWS_TIMEOUT_EN
    tr = ptr; tother = 1 - tr;
    drive_beat(tother, 6'd9, 24'h55, 1'b0);
    drive_beat(tr, 6'd0, 24'd0, 1'b0);
    step();
    exp_pend = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("to_ready", req_ready, 64'(1) << tr);
      chk_wr();
      drive_beat(tr, 6'(k), 24'(k + 100), 1'b0);
      step();
      exp_pend = 1'b1; exp_addr = 6'(k); exp_data = 24'(k + 100);
    end
    chk_wr();
    exp_pend = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      req_valid[tr] = 1'b0;
      step();
      chk("to_pulse", timeout_err, k == 16);
      chk("to_busy", busy, k != 16);
      chk("to_send", send_frame, 0);
    end
    step();
    chk("to_single", timeout_err, 0);
    chk("to_next_grant", grant_id, tother);
    chk("to_next_ready", req_ready, 64'(1) << tother);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
